game_fsm: RTL and testbench

Game-control stage directly downstream of the player sprite and pipe generator. Each frame it watches the pixel stream for overlap between the player and pipe sprites, checks the player's y coordinate against the floor, and sequences the game through idle, play and over. It drives the `game_state` bus that the player and pipe stages consume, and keeps a 3-digit BCD score plus a best score for the score overlay.

---
 rtl/game_fsm_if.sv | 46 ++++
 rtl/game_fsm.sv | 170 +++++++++++++++++
 tb/tb_game_fsm.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : game_fsm_if
//  Purpose  : Bundles the per-pixel inputs and the game-control outputs of
//             game_fsm into one interface.
//  Signals  : btnU       - debounced jump/start button (level)
//             video_on   - display-area flag
//             x, y       - current pixel coordinates (10 bits each)
//             player_on  - player sprite pixel active
//             pipe_on    - pipe sprite pixel active
//             p_y        - player top-left y (10 bits)
//             pipe_pass  - one-cycle pulse, a pipe passed the player
//             game_state - 01 idle, 10 play, 11 over
//             score      - 3-digit BCD score
//             hi_score   - 3-digit BCD best score
//             collision  - high while in over
//  Modports : master - pixel/sprite source, consumes game outputs
//             slave  - game_fsm itself
//  Revision : 1.0 - initial release
// ============================================================================
interface game_fsm_if;
    logic        btnU;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        player_on;
    logic        pipe_on;
    logic [9:0]  p_y;
    logic        pipe_pass;
    logic [1:0]  game_state;
    logic [11:0] score;
    logic [11:0] hi_score;
    logic        collision;

    modport master (
        output btnU, video_on, x, y, player_on, pipe_on, p_y, pipe_pass,
        input  game_state, score, hi_score, collision
    );

    modport slave (
        input  btnU, video_on, x, y, player_on, pipe_on, p_y, pipe_pass,
        output game_state, score, hi_score, collision
    );
endinterface
`default_nettype wire

// File: rtl/game_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : game_fsm
//  Purpose  : Game-control stage. Watches the pixel stream for player/pipe
//             overlap, checks the player against the floor once per frame,
//             sequences idle -> play -> over -> idle and keeps a BCD score.
//  Ports    : clk   - pixel-domain clock
//             reset - asynchronous, active-low reset
//             bus   - game_fsm_if.slave (pixel inputs, game outputs)
//  Params   : MAX_Y       - visible lines, also the frame-tick line
//             T_H         - player sprite height (floor = MAX_Y - T_H)
//             OVER_FRAMES - frames the over state ignores the button
//  Macro    : GAME_FSM_HI_SCORE_EN - when defined, a best-score register is
//             built; otherwise hi_score is tied to 000.
//  Revision : 1.0 - initial release
// ============================================================================
module game_fsm #(
    parameter int MAX_Y       = 480,
    parameter int T_H         = 24,
    parameter int OVER_FRAMES = 60
) (
    input  wire logic   clk,
    input  wire logic   reset,
    game_fsm_if.slave   bus
);
    localparam int                 c_CNT_W     = $clog2(OVER_FRAMES + 1);
    localparam logic [9:0]         c_TICK_Y    = 10'(MAX_Y);
    localparam logic [9:0]         c_FLOOR_Y   = 10'(MAX_Y - T_H);
    localparam logic [c_CNT_W-1:0] c_OVER_LOAD = c_CNT_W'(OVER_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_PLAY = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_btn_sync;
    logic                 r_btn_prev;
    logic                 r_hit_frame;
    logic                 w_hit_next;
    logic [c_CNT_W-1:0]   r_over_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [11:0]          r_score;
    logic [11:0]          w_score_next;
    logic                 r_collision;
    logic                 w_collision_next;

    logic                 w_frame_tick;
    logic                 w_btn_edge;
    logic                 w_overlap;
    logic                 w_floor_hit;
    logic                 w_hit_any;

    // BCD +1 with ripple carry across digits, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d2, d1, d0;
        {d2, d1, d0} = v;
        if (v == 12'h999)
            return v;
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    assign w_frame_tick = (bus.x == 10'd0) && (bus.y == c_TICK_Y);
    // Edge is taken after the two-flop sampler, so it trails btnU by two cycles.
    assign w_btn_edge   = r_btn_sync[1] & ~r_btn_prev;
    assign w_overlap    = bus.player_on & bus.pipe_on & bus.video_on;
    assign w_floor_hit  = (bus.p_y >= c_FLOOR_Y);
    // Includes an overlap on the current cycle so a hit on the tick pixel
    // still counts toward the frame being closed.
    assign w_hit_any    = r_hit_frame | ((r_state == ST_PLAY) & w_overlap);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        w_score_next     = r_score;
        w_cnt_next       = r_over_cnt;
        w_collision_next = r_collision;
        w_hit_next       = w_frame_tick ? 1'b0 : w_hit_any;
        case (r_state)
            ST_IDLE: begin
                if (w_btn_edge) begin
                    w_state_next = ST_PLAY;
                    w_score_next = 12'h000;
                end
            end
            ST_PLAY: begin
                if (bus.pipe_pass)
                    w_score_next = bcd_inc(r_score);
                if (w_frame_tick && (w_hit_any || w_floor_hit)) begin
                    w_state_next     = ST_OVER;
                    w_collision_next = 1'b1;
                    w_cnt_next       = c_OVER_LOAD;
                end
            end
            ST_OVER: begin
                if (w_frame_tick && (r_over_cnt != '0))
                    w_cnt_next = r_over_cnt - 1'b1;
                if (w_btn_edge && (r_over_cnt == '0)) begin
                    w_state_next     = ST_IDLE;
                    w_collision_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_sync  <= 2'b00;
            r_btn_prev  <= 1'b0;
            r_hit_frame <= 1'b0;
            r_over_cnt  <= '0;
            r_score     <= 12'h000;
            r_collision <= 1'b0;
        end else begin
            r_btn_sync  <= {r_btn_sync[0], bus.btnU};
            r_btn_prev  <= r_btn_sync[1];
            r_hit_frame <= w_hit_next;
            r_over_cnt  <= w_cnt_next;
            r_score     <= w_score_next;
            r_collision <= w_collision_next;
        end
    end

`ifdef GAME_FSM_HI_SCORE_EN
    logic [11:0] r_hi_score;

    // Compares against the score the game ends with, i.e. including a
    // pipe_pass that lands on the game-over cycle. Packed BCD compares
    // correctly as a plain unsigned number (hundreds digit is most significant).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_hi_score <= 12'h000;
        else if ((r_state == ST_PLAY) && (w_state_next == ST_OVER) &&
                 (w_score_next > r_hi_score))
            r_hi_score <= w_score_next;
    end

    assign bus.hi_score = r_hi_score;
`else
    assign bus.hi_score = 12'h000;
`endif

    assign bus.game_state = r_state;
    assign bus.score      = r_score;
    assign bus.collision  = r_collision;
endmodule
`default_nettype wire

// File: tb/tb_game_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_game_fsm
//  Purpose  : Self-checking bench for game_fsm. A behavioural model predicts
//             the outputs after every clock edge; predictions go into a queue
//             and a negedge monitor pops and compares them.
//  Macro    : GAME_FSM_HI_SCORE_EN selects the hi_score expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_fsm;
    localparam int MAX_Y       = 480;
    localparam int T_H         = 24;
    localparam int OVER_FRAMES = 60;

    logic clk = 1'b0;
    logic reset;

    game_fsm_if bus();

    game_fsm #(
        .MAX_Y       (MAX_Y),
        .T_H         (T_H),
        .OVER_FRAMES (OVER_FRAMES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  gs;
        logic [11:0] sc;
        logic [11:0] hi;
        logic        col;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 play, 2 over. Score kept as an integer.
    int m_mode;
    int m_score;
    int m_hi;
    int m_lock;
    bit m_hit;
    bit m_hist[$];   // m_hist[k] = btnU level k cycles ago

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gs  = (m_mode == 0) ? 2'b01 : (m_mode == 1) ? 2'b10 : 2'b11;
        e.sc  = to_bcd(m_score);
`ifdef GAME_FSM_HI_SCORE_EN
        e.hi  = to_bcd(m_hi);
`else
        e.hi  = 12'h000;
`endif
        e.col = (m_mode == 2);
        return e;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_score = 0;
        m_hi    = 0;
        m_lock  = 0;
        m_hit   = 0;
        m_hist.delete();
        repeat (4) m_hist.push_back(1'b0);
    endtask

    task automatic model_step();
        bit tick, ovl, press;
        m_hist.push_front(bus.btnU);
        void'(m_hist.pop_back());
        press = m_hist[2] && !m_hist[3];
        tick  = (bus.x == 10'd0) && (bus.y == 10'(MAX_Y));
        ovl   = bus.player_on && bus.pipe_on && bus.video_on;
        case (m_mode)
            0: begin
                if (press) begin
                    m_mode  = 1;
                    m_score = 0;
                end
            end
            1: begin
                if (bus.pipe_pass && m_score < 999) m_score++;
                if (ovl) m_hit = 1;
                if (tick && (m_hit || int'(bus.p_y) >= MAX_Y - T_H)) begin
                    m_mode = 2;
                    m_lock = OVER_FRAMES;
                    if (m_score > m_hi) m_hi = m_score;
                end
            end
            default: begin
                if (press && m_lock == 0) m_mode = 0;
                else if (tick && m_lock > 0) m_lock--;
            end
        endcase
        if (tick) m_hit = 0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp_v, $time);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("game_state", {10'd0, bus.game_state}, {10'd0, mon_e.gs});
            check("score",      bus.score,               mon_e.sc);
            check("hi_score",   bus.hi_score,            mon_e.hi);
            check("collision",  {11'd0, bus.collision},  {11'd0, mon_e.col});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        model_step();
        @(posedge clk);
        exp_q.push_back(model_out());
        #1;
    endtask

    // Called at posedge+1: the pending prediction for this cycle is replaced,
    // since outputs must already show reset values before the next edge.
    task automatic hold_reset(input int n);
        reset = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = model_out();
        else exp_q.push_back(model_out());
        repeat (n) begin
            @(posedge clk);
            exp_q.push_back(model_out());
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic set_idle_inputs();
        bus.btnU      = 1'b0;
        bus.video_on  = 1'b1;
        bus.x         = 10'd100;
        bus.y         = 10'd100;
        bus.player_on = 1'b0;
        bus.pipe_on   = 1'b0;
        bus.p_y       = 10'd200;
        bus.pipe_pass = 1'b0;
    endtask

    task automatic press();
        bus.btnU = 1'b1;
        repeat (4) cyc();
        bus.btnU = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.x = 10'd0; bus.y = 10'(MAX_Y); bus.video_on = 1'b0;
            cyc();
            bus.x = 10'd100; bus.y = 10'd100; bus.video_on = 1'b1;
            cyc();
        end
    endtask

    task automatic passes(input int n);
        repeat (n) begin
            bus.pipe_pass = 1'b1;
            cyc();
            bus.pipe_pass = 1'b0;
            cyc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        set_idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        hold_reset(5);
        repeat (3) cyc();

        // start, score carry, pipe collision
        press();
        passes(9);
        passes(1);
        passes(2);
        bus.x = 10'd95; bus.y = 10'd200; bus.player_on = 1'b1; bus.pipe_on = 1'b1;
        cyc();
        bus.player_on = 1'b0; bus.pipe_on = 1'b0; bus.x = 10'd100; bus.y = 10'd100;
        repeat (5) cyc();
        ticks(1);

        // lockout: press at frame 30 ignored, press after 60 frames returns idle
        ticks(30);
        press();
        ticks(30);
        press();

        // game 2: floor hit with a lower score
        press();
        passes(5);
        bus.p_y = 10'(MAX_Y - T_H);
        ticks(1);
        bus.p_y = 10'd200;
        ticks(OVER_FRAMES);
        press();

        // game 3: saturation at 999, then reset mid-game
        press();
        bus.pipe_pass = 1'b1;
        repeat (1000) cyc();
        bus.pipe_pass = 1'b0;
        cyc();
        hold_reset(3);
        repeat (2) cyc();

        // game 4: reset mid-game with score 007
        press();
        passes(7);
        hold_reset(3);
        repeat (2) cyc();

        // randomized phase
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.btnU = ~bus.btnU;
            bus.pipe_pass = ($urandom_range(0, 3) == 0);
            bus.video_on  = 1'($urandom_range(0, 1));
            bus.player_on = ($urandom_range(0, 7) == 0);
            bus.pipe_on   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) begin
                bus.x = 10'd0;
                bus.y = 10'(MAX_Y);
            end else begin
                bus.x = 10'($urandom_range(0, 639));
                bus.y = 10'($urandom_range(0, 479));
            end
            bus.p_y = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(450, 470))
                                                   : 10'($urandom_range(0, 400));
            if (i == 3000) hold_reset(2);
            else cyc();
        end

        set_idle_inputs();
        repeat (2) cyc();
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
